regfile: RTL and testbench
==========================

# regfile

Architectural general-purpose register file at the far end of the writeback interface. It accepts the write address, data and enable leaving the MEM/WB pipeline register, and serves two combinational read ports to the decode stage. It also registers a one-cycle-delayed writeback trace for debug and difftest comparison.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers. Address width is `RegAddrBus` (5 bits).
- `DATA_W`, 32: register width, equal to `RegBus`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-low (`RstEnable` = 1'b0).
- `we`  in  1: write enable from writeback (`WriteEnable` = 1).
- `waddr`  in  5: write register number.
- `wdata`  in  32: write data.
- `re1`  in  1: read port 1 enable.
- `raddr1`  in  5: read port 1 register number.
- `rdata1`  out  32: read port 1 data, combinational.
- `re2`  in  1: read port 2 enable.
- `raddr2`  in  5: read port 2 register number.
- `rdata2`  out  32: read port 2 data, combinational.
- `debug_wb_rf_wen`  out  1: registered "a write committed last cycle".
- `debug_wb_rf_wnum`  out  5: registered number of the committed register.
- `debug_wb_rf_wdata`  out  32: registered value of the committed write.
- `wr_count`  out  32: count of committed writes since reset.

## Operation
- Storage is 32 x 32 bits. r0 is hardwired to zero: writes to r0 are discarded, and reads of r0 return `ZeroWord`.
- Commit condition is `we`==1 && `waddr`!=0. On commit, at the rising edge:
  - the array entry at `waddr` takes `wdata`;
  - the debug trace registers load 1, `waddr` and `wdata`;
  - `wr_count` increments by 1, wrapping from 0xFFFFFFFF to 0 with no flag.
- With no commit, `debug_wb_rf_wen` loads 0 and the other two trace outputs hold their previous values.
- Read priority for each port, highest first:
  1. `re`==0 gives `ZeroWord`.
  2. `raddr`==0 gives `ZeroWord`.
  3. Bypass hit (only when compiled in): `we`==1 && `waddr`==`raddr` gives `wdata`.
  4. Otherwise the array entry.
- Both ports are independent. Both may read the same register, and either or both may hit the bypass in the same cycle.
- `we`==1 with `waddr`==0 commits nothing. It produces no trace, no count increment and no bypass.

## Timing
- Write latency: data is visible in the array from the cycle after the commit edge.
- With bypass compiled in, a read of the register being written returns the new data in the same cycle.
- Read latency: zero cycles (combinational from `raddr`, `re` and the bypass inputs).
- Trace latency: the debug outputs reflect a commit exactly one cycle after `we` was sampled.
- Reset value of every output while `rst`==0:
  - all array entries are 0, so `rdata1` and `rdata2` read 0;
  - `debug_wb_rf_wen` = 0, `debug_wb_rf_wnum` = 0, `debug_wb_rf_wdata` = 0;
  - `wr_count` = 0.
- Reset asserted mid-operation clears all state immediately, with no clock needed. A write arriving in the same cycle as reset is lost.
- Reset release is not synchronized here. The first commit is possible on the first rising edge with `rst`==1.

## Configuration
- `REGFILE_BYPASS_EN` defined: the same-cycle write-to-read forwarding path (read priority 3) is present.
- `REGFILE_BYPASS_EN` undefined: reads return array contents only. A same-cycle write-then-read returns the old value, and the pipeline must cover that hazard elsewhere.

## Structure
- `Defines.v` (shared include) holds the constants used here:
  - bus widths: `RegAddrBus`, `RegBus`;
  - register count: `RegNum`;
  - reset and write values: `ZeroWord`, `NOPRegAddr`, `RstEnable`;
  - enable values: `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`.
- The read-port selection logic is one sub-module, `regfile_rport`, instantiated twice. It takes `re`, `raddr`, the array word, `we`, `waddr` and `wdata`, and produces `rdata`.

## Test plan
- Reset, then read every address on both ports: all return 0. Debug outputs are 0 and `wr_count`=0.
- Write r5=0xDEADBEEF, then read `raddr1`=5 next cycle: 0xDEADBEEF. `debug_wb_rf_wen`=1, wnum=5, wdata=0xDEADBEEF one cycle after the write. `wr_count`=1.
- Write r0=0x12345678, then read r0: 0. Also `debug_wb_rf_wen`=0 and `wr_count` unchanged.
- Bypass: r7 holds 1. Drive `we`=1, `waddr`=7, `wdata`=2 with `raddr1`=`raddr2`=7 in the same cycle:
  - both ports return 2 with `REGFILE_BYPASS_EN`;
  - both return 1 without it.
- `re1`=0 with `raddr1`=5 (r5 nonzero): `rdata1`=0 while `rdata2` reads r5 normally.
- Write r3=0xA5A5A5A5, then assert `rst` asynchronously between clock edges: r3, the trace outputs and `wr_count` read 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the architectural register file and its read ports.
package regfile_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic                  RstEnable    = 1'b0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  ReadEnable   = 1'b1;
  localparam logic                  ReadDisable  = 1'b0;

  // r0 is hardwired, so a write to it never counts as a commit.
  function automatic logic is_commit(input logic we, input logic [RegAddrBus-1:0] waddr);
    return (we == WriteEnable) && (waddr != NOPRegAddr);
  endfunction

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: enable, r0, optional same-cycle bypass, array.
// Bypass path compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  re,
  input  logic [RegAddrBus-1:0] raddr,
  input  logic [DATA_W-1:0]     arr_word,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic bypass_hit;

  assign bypass_hit = BypassEn && (we == WriteEnable) && (waddr == raddr);

  always_comb begin
    rdata = '0;
    if (re == ReadDisable || raddr == NOPRegAddr) begin
      rdata = '0;
    end else if (bypass_hit) begin
      rdata = wdata;
    end else begin
      rdata = arr_word;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32x32 general-purpose register file with two combinational read ports,
// a one-cycle writeback trace and a commit counter. Option: REGFILE_BYPASS_EN.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int DATA_W  = RegBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [DATA_W-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata2,
  output logic                  debug_wb_rf_wen,
  output logic [RegAddrBus-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata,
  output logic [31:0]           wr_count
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic              commit;

  assign commit = is_commit(we, waddr);

  // Entry 0 is only ever cleared, never written, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      debug_wb_rf_wen   <= 1'b0;
      debug_wb_rf_wnum  <= NOPRegAddr;
      debug_wb_rf_wdata <= '0;
      wr_count          <= '0;
    end else begin
      debug_wb_rf_wen <= commit;
      if (commit) begin
        debug_wb_rf_wnum  <= waddr;
        debug_wb_rf_wdata <= wdata;
        wr_count          <= wr_count + 32'd1;
      end
    end
  end

  regfile_rport #(.DATA_W(DATA_W)) u_rport1 (
    .re       (re1),
    .raddr    (raddr1),
    .arr_word (regs[raddr1]),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata1)
  );

  regfile_rport #(.DATA_W(DATA_W)) u_rport2 (
    .re       (re2),
    .raddr    (raddr2),
    .arr_word (regs[raddr2]),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] wr_count;

  int total = 0;
  int bad   = 0;

  regfile dut (
    .clk               (clk),
    .rst               (rst),
    .we                (we),
    .waddr             (waddr),
    .wdata             (wdata),
    .re1               (re1),
    .raddr1            (raddr1),
    .rdata1            (rdata1),
    .re2               (re2),
    .raddr2            (raddr2),
    .rdata2            (rdata2),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .wr_count          (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = '0; re2 = 1'b1; raddr2 = '0;
    #12;
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0];
      raddr2 = 5'(31 - a);
      #1;
      total++;
      if (rdata1 !== 32'h0) begin
        bad++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", a, rdata1, 32'h0);
      end
      total++;
      if (rdata2 !== 32'h0) begin
        bad++; $display("FAIL reset_rd2[%0d] got=%h exp=%h", 31 - a, rdata2, 32'h0);
      end
    end
    total++;
    if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 38'h0) begin
      bad++; $display("FAIL reset_trace got=%b/%h/%h exp=0/00/00000000",
                      debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    total++;
    if (wr_count !== 32'd0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", wr_count);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_r5 got=%h exp=deadbeef", rdata1);
    end
    total++;
    if (debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_trace got=%b/%0d/%h exp=1/5/deadbeef",
                      debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    total++;
    if (wr_count !== 32'd1) begin
      bad++; $display("FAIL write_count got=%0d exp=1", wr_count);
    end
    tick();
    total++;
    if (debug_wb_rf_wen !== 1'b0 || debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL trace_hold got=%b/%0d/%h exp=0/5/deadbeef",
                      debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
  endtask

  task automatic test_r0;
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; re1 = 1'b1; raddr1 = 5'd0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL r0_same_cycle got=%h exp=00000000", rdata1);
    end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL r0_read got=%h exp=00000000", rdata1);
    end
    total++;
    if (debug_wb_rf_wen !== 1'b0 || debug_wb_rf_wnum !== 5'd5) begin
      bad++; $display("FAIL r0_trace got=%b/%0d exp=0/5", debug_wb_rf_wen, debug_wb_rf_wnum);
    end
    total++;
    if (wr_count !== 32'd1) begin
      bad++; $display("FAIL r0_count got=%0d exp=1", wr_count);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'd2;
`else
    exp_same = 32'd1;
`endif
    we = 1'b1; waddr = 5'd7; wdata = 32'd1;
    tick();
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    wdata = 32'd2;
    #1;
    total++;
    if (rdata1 !== exp_same) begin
      bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rdata1, exp_same);
    end
    total++;
    if (rdata2 !== exp_same) begin
      bad++; $display("FAIL bypass_rd2 got=%h exp=%h", rdata2, exp_same);
    end
    re1 = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL bypass_re_off got=%h exp=00000000", rdata1);
    end
    re1 = 1'b1;
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'd2 || rdata2 !== 32'd2) begin
      bad++; $display("FAIL after_bypass got=%h/%h exp=2/2", rdata1, rdata2);
    end
    total++;
    if (wr_count !== 32'd3 || debug_wb_rf_wnum !== 5'd7 || debug_wb_rf_wdata !== 32'd2) begin
      bad++; $display("FAIL bypass_trace got=%0d/%0d/%h exp=3/7/2",
                      wr_count, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
  endtask

  task automatic test_re_disable;
    re1 = 1'b0; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL re1_off got=%h exp=00000000", rdata1);
    end
    total++;
    if (rdata2 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL re2_on got=%h exp=deadbeef", rdata2);
    end
    re1 = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222;
    vals[2] = 32'h33333333; vals[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; waddr = 5'(i + 1); wdata = vals[i];
      tick();
      total++;
      if (debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5'(i + 1) || debug_wb_rf_wdata !== vals[i]) begin
        bad++; $display("FAIL b2b_trace[%0d] got=%b/%0d/%h exp=1/%0d/%h", i,
                        debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, i + 1, vals[i]);
      end
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raddr1 = 5'(i + 1); raddr2 = 5'(4 - i);
      #1;
      total++;
      if (rdata1 !== vals[i] || rdata2 !== vals[3 - i]) begin
        bad++; $display("FAIL b2b_read[%0d] got=%h/%h exp=%h/%h", i,
                        rdata1, rdata2, vals[i], vals[3 - i]);
      end
    end
    total++;
    if (wr_count !== 32'd7) begin
      bad++; $display("FAIL b2b_count got=%0d exp=7", wr_count);
    end
  endtask

  task automatic test_async_reset;
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0; raddr1 = 5'd3;
    #1;
    total++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL pre_reset_r3 got=%h exp=a5a5a5a5", rdata1);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL async_r3 got=%h exp=00000000", rdata1);
    end
    total++;
    if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 38'h0 || wr_count !== 32'd0) begin
      bad++; $display("FAIL async_state got=%b/%0d/%h/%0d exp=0/0/0/0",
                      debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, wr_count);
    end
    we = 1'b1; waddr = 5'd9; wdata = 32'h1;
    tick();
    raddr1 = 5'd9; we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0 || wr_count !== 32'd0) begin
      bad++; $display("FAIL write_in_reset got=%h/%0d exp=0/0", rdata1, wr_count);
    end
    #2 rst = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h55 || wr_count !== 32'd1) begin
      bad++; $display("FAIL first_commit got=%h/%0d exp=55/1", rdata1, wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_r0();
    test_bypass();
    test_re_disable();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
